// File: rtl/synth_cmd_decoder_if.sv
// Byte stream in from the SPI receiver and per-channel oscillator settings out.
// The master side feeds bytes; the slave side is the decoder.
interface synth_cmd_decoder_if #(
    parameter int unsigned N_OSC   = 2,
    parameter int unsigned WAVE_W  = 3,
    parameter int unsigned FREQ_W  = 24,
    parameter int unsigned PHASE_W = 16,
    parameter int unsigned AMP_W   = 16
) ();
    logic [7:0]               i_rx_byte;
    logic                     i_rx_valid;
    logic [N_OSC*WAVE_W-1:0]  o_wave;
    logic [N_OSC*FREQ_W-1:0]  o_freq;
    logic [N_OSC*PHASE_W-1:0] o_phase;
    logic [N_OSC*AMP_W-1:0]   o_amp;
    logic [N_OSC-1:0]         o_update;
    logic                     o_err;
    logic                     o_busy;

    modport master (
        output i_rx_byte, i_rx_valid,
        input  o_wave, o_freq, o_phase, o_amp, o_update, o_err, o_busy
    );

    modport slave (
        input  i_rx_byte, i_rx_valid,
        output o_wave, o_freq, o_phase, o_amp, o_update, o_err, o_busy
    );
endinterface

// File: rtl/synth_cmd_decoder.sv
// SPI command decoder and shadow register file for N_OSC oscillator channels.
// Payload bytes are assembled little-endian and committed atomically on the last byte.
module synth_cmd_decoder #(
    parameter int unsigned N_OSC          = 2,
    parameter int unsigned WAVE_W         = 3,
    parameter int unsigned FREQ_W         = 24,
    parameter int unsigned PHASE_W        = 16,
    parameter int unsigned AMP_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
    input  logic                i_clk50mhz,
    input  logic                i_rst,
    synth_cmd_decoder_if.slave  bus
);
    localparam int unsigned WAVE_B  = (WAVE_W + 7) / 8;
    localparam int unsigned FREQ_B  = (FREQ_W + 7) / 8;
    localparam int unsigned PHASE_B = (PHASE_W + 7) / 8;
    localparam int unsigned AMP_B   = (AMP_W + 7) / 8;
    localparam int unsigned MAX_WF  = (WAVE_B > FREQ_B) ? WAVE_B : FREQ_B;
    localparam int unsigned MAX_PA  = (PHASE_B > AMP_B) ? PHASE_B : AMP_B;
    localparam int unsigned MAX_B   = (MAX_WF > MAX_PA) ? MAX_WF : MAX_PA;
    localparam int unsigned ASM_W   = MAX_B * 8;
    localparam int unsigned CNT_W   = $clog2(MAX_B + 1);
    localparam int unsigned TO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [3:0] R_WAVE  = 4'd1;
    localparam logic [3:0] R_FREQ  = 4'd2;
    localparam logic [3:0] R_PHASE = 4'd3;
    localparam logic [3:0] R_AMP   = 4'd4;

    typedef enum logic {S_IDLE, S_PAYLOAD} state_t;

    state_t                   state_q, state_n;
    logic [3:0]               ch_q, ch_n;
    logic [3:0]               rcode_q, rcode_n;
    logic [CNT_W-1:0]         left_q, left_n;
    logic [CNT_W-1:0]         idx_q, idx_n;
    logic [ASM_W-1:0]         asm_q, asm_n, asm_full;
    logic [TO_W-1:0]          to_q, to_n;
    logic [N_OSC*WAVE_W-1:0]  wave_q, wave_n;
    logic [N_OSC*FREQ_W-1:0]  freq_q, freq_n;
    logic [N_OSC*PHASE_W-1:0] phase_q, phase_n;
    logic [N_OSC*AMP_W-1:0]   amp_q, amp_n;
    logic [N_OSC-1:0]         upd_q, upd_n;
    logic                     err_q, err_n;
    logic                     busy_q;

    logic [3:0]               cmd_ch;
    logic [3:0]               cmd_code;
    logic                     cmd_ok;
    logic [CNT_W-1:0]         cmd_len;

    assign cmd_ch   = bus.i_rx_byte[7:4];
    assign cmd_code = bus.i_rx_byte[3:0];

    // Command validation and payload length lookup
    always_comb begin
        cmd_ok  = 1'b0;
        cmd_len = '0;
        case (cmd_code)
            R_WAVE:  cmd_len = CNT_W'(WAVE_B);
            R_FREQ:  cmd_len = CNT_W'(FREQ_B);
            R_PHASE: cmd_len = CNT_W'(PHASE_B);
            R_AMP:   cmd_len = CNT_W'(AMP_B);
            default: cmd_len = '0;
        endcase
        if ((cmd_len != '0) && (32'(cmd_ch) < N_OSC)) begin
            cmd_ok = 1'b1;
        end
    end

    // Next-state, payload assembly, commit and timeout
    always_comb begin
        state_n  = state_q;
        ch_n     = ch_q;
        rcode_n  = rcode_q;
        left_n   = left_q;
        idx_n    = idx_q;
        asm_n    = asm_q;
        to_n     = to_q;
        wave_n   = wave_q;
        freq_n   = freq_q;
        phase_n  = phase_q;
        amp_n    = amp_q;
        upd_n    = '0;
        err_n    = 1'b0;
        asm_full = asm_q;
        asm_full[32'(idx_q) * 32'd8 +: 8] = bus.i_rx_byte;

        case (state_q)
            S_IDLE: begin
                if (bus.i_rx_valid && (bus.i_rx_byte != 8'h00)) begin
                    if (cmd_ok) begin
                        state_n = S_PAYLOAD;
                        ch_n    = cmd_ch;
                        rcode_n = cmd_code;
                        left_n  = cmd_len;
                        idx_n   = '0;
                        asm_n   = '0;
                        to_n    = '0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            S_PAYLOAD: begin
                if (bus.i_rx_valid) begin
                    to_n = '0;
                    if (left_q == CNT_W'(1)) begin
                        state_n = S_IDLE;
                        upd_n   = N_OSC'(1) << ch_q;
                        case (rcode_q)
                            R_WAVE:  wave_n[32'(ch_q) * WAVE_W +: WAVE_W]   = asm_full[WAVE_W-1:0];
                            R_FREQ:  freq_n[32'(ch_q) * FREQ_W +: FREQ_W]   = asm_full[FREQ_W-1:0];
                            R_PHASE: phase_n[32'(ch_q) * PHASE_W +: PHASE_W] = asm_full[PHASE_W-1:0];
                            R_AMP:   amp_n[32'(ch_q) * AMP_W +: AMP_W]      = asm_full[AMP_W-1:0];
                            default: upd_n = '0;
                        endcase
                    end else begin
                        asm_n  = asm_full;
                        idx_n  = idx_q + CNT_W'(1);
                        left_n = left_q - CNT_W'(1);
                    end
                end else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_n = S_IDLE;
                    err_n   = 1'b1;
                end else begin
                    to_n = to_q + TO_W'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk50mhz) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            rcode_q <= '0;
            left_q  <= '0;
            idx_q   <= '0;
            asm_q   <= '0;
            to_q    <= '0;
            wave_q  <= '0;
            freq_q  <= '0;
            phase_q <= '0;
            amp_q   <= '0;
            upd_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            ch_q    <= ch_n;
            rcode_q <= rcode_n;
            left_q  <= left_n;
            idx_q   <= idx_n;
            asm_q   <= asm_n;
            to_q    <= to_n;
            wave_q  <= wave_n;
            freq_q  <= freq_n;
            phase_q <= phase_n;
            amp_q   <= amp_n;
            upd_q   <= upd_n;
            err_q   <= err_n;
            busy_q  <= (state_n == S_PAYLOAD);
        end
    end

    assign bus.o_wave   = wave_q;
    assign bus.o_freq   = freq_q;
    assign bus.o_phase  = phase_q;
    assign bus.o_amp    = amp_q;
    assign bus.o_update = upd_q;
    assign bus.o_err    = err_q;
    assign bus.o_busy   = busy_q;
endmodule

// File: tb/tb_synth_cmd_decoder.sv
// Scoreboard bench for synth_cmd_decoder: a register model predicts every update/error
// pulse and the full output vectors at that moment.
module tb_synth_cmd_decoder;
    localparam int unsigned N_OSC   = 2;
    localparam int unsigned WAVE_W  = 3;
    localparam int unsigned FREQ_W  = 24;
    localparam int unsigned PHASE_W = 16;
    localparam int unsigned AMP_W   = 16;
    localparam int unsigned TMO     = 100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    synth_cmd_decoder_if #(
        .N_OSC(N_OSC), .WAVE_W(WAVE_W), .FREQ_W(FREQ_W), .PHASE_W(PHASE_W), .AMP_W(AMP_W)
    ) bus ();

    synth_cmd_decoder #(
        .N_OSC(N_OSC), .WAVE_W(WAVE_W), .FREQ_W(FREQ_W), .PHASE_W(PHASE_W), .AMP_W(AMP_W),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk50mhz(clk),
        .i_rst     (rst),
        .bus       (bus)
    );

    typedef struct {
        logic [N_OSC-1:0]         upd;
        logic                     err;
        logic [N_OSC*WAVE_W-1:0]  wave;
        logic [N_OSC*FREQ_W-1:0]  freq;
        logic [N_OSC*PHASE_W-1:0] phase;
        logic [N_OSC*AMP_W-1:0]   amp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    logic [N_OSC*WAVE_W-1:0]  m_wave;
    logic [N_OSC*FREQ_W-1:0]  m_freq;
    logic [N_OSC*PHASE_W-1:0] m_phase;
    logic [N_OSC*AMP_W-1:0]   m_amp;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [N_OSC-1:0] upd, input logic err);
        exp_t e;
        e.upd   = upd;
        e.err   = err;
        e.wave  = m_wave;
        e.freq  = m_freq;
        e.phase = m_phase;
        e.amp   = m_amp;
        sb.push_back(e);
    endtask

    task automatic commit(input int ch, input int code, input logic [31:0] val);
        case (code)
            1: m_wave[ch*WAVE_W +: WAVE_W]    = val[WAVE_W-1:0];
            2: m_freq[ch*FREQ_W +: FREQ_W]    = val[FREQ_W-1:0];
            3: m_phase[ch*PHASE_W +: PHASE_W] = val[PHASE_W-1:0];
            default: m_amp[ch*AMP_W +: AMP_W] = val[AMP_W-1:0];
        endcase
        push(N_OSC'(1) << ch, 1'b0);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.i_rx_byte  = b;
        bus.i_rx_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.i_rx_byte  = 8'h00;
            bus.i_rx_valid = 1'b0;
        end
    endtask

    task automatic check_outs(input string tag);
        check({tag, "_wave"},  64'(bus.o_wave),  64'(m_wave));
        check({tag, "_freq"},  64'(bus.o_freq),  64'(m_freq));
        check({tag, "_phase"}, 64'(bus.o_phase), 64'(m_phase));
        check({tag, "_amp"},   64'(bus.o_amp),   64'(m_amp));
    endtask

    // Every update/error pulse must match the oldest prediction
    always @(negedge clk) begin
        if (!rst && ((bus.o_update != '0) || bus.o_err)) begin
            if (sb.size() == 0) begin
                check("unexpected_evt", 64'({bus.o_update, bus.o_err}), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("evt_update", 64'(bus.o_update), 64'(e.upd));
                check("evt_err",    64'(bus.o_err),    64'(e.err));
                check("evt_wave",   64'(bus.o_wave),   64'(e.wave));
                check("evt_freq",   64'(bus.o_freq),   64'(e.freq));
                check("evt_phase",  64'(bus.o_phase),  64'(e.phase));
                check("evt_amp",    64'(bus.o_amp),    64'(e.amp));
            end
        end
    end

    initial begin
        int lat;
        int ch;
        int code;
        int nb;
        logic [31:0] val;

        rst            = 1'b1;
        bus.i_rx_byte  = 8'h00;
        bus.i_rx_valid = 1'b0;
        m_wave  = '0;
        m_freq  = '0;
        m_phase = '0;
        m_amp   = '0;
        repeat (3) @(negedge clk);
        check_outs("rst");
        check("rst_update", 64'(bus.o_update), 64'(0));
        check("rst_err",    64'(bus.o_err),    64'(0));
        check("rst_busy",   64'(bus.o_busy),   64'(0));
        rst = 1'b0;
        idle(2);

        // Null bytes around a one-byte wave write
        send(8'h00);
        send(8'h01);
        send(8'h05);
        commit(0, 1, 32'h5);
        send(8'h00);
        idle(3);

        // Three-byte frequency write on channel 1; old value held until commit
        check("t2_busy_pre", 64'(bus.o_busy), 64'(0));
        send(8'h12);
        send(8'hFF);
        check("t2_busy_b1", 64'(bus.o_busy), 64'(1));
        check("t2_freq_b1", 64'(bus.o_freq), 64'(m_freq));
        send(8'hFF);
        check("t2_busy_b2", 64'(bus.o_busy), 64'(1));
        check("t2_freq_b2", 64'(bus.o_freq), 64'(m_freq));
        send(8'h07);
        check("t2_busy_b3", 64'(bus.o_busy), 64'(1));
        commit(1, 2, 32'h07FFFF);
        idle(1);
        check("t2_busy_post", 64'(bus.o_busy), 64'(0));
        check("t2_freq1", 64'(bus.o_freq[FREQ_W +: FREQ_W]), 64'h07FFFF);
        idle(2);

        // Back-to-back frames with no gap after the first commit
        send(8'h04);
        send(8'hFF);
        send(8'h7F);
        commit(0, 4, 32'h7FFF);
        send(8'h03);
        send(8'hFF);
        send(8'h03);
        commit(0, 3, 32'h03FF);
        idle(3);
        check("t3_amp0",   64'(bus.o_amp[AMP_W-1:0]),     64'h7FFF);
        check("t3_phase0", 64'(bus.o_phase[PHASE_W-1:0]), 64'h03FF);

        // Bad channel then bad register code
        send(8'h25);
        push('0, 1'b1);
        send(8'h07);
        push('0, 1'b1);
        idle(3);
        check("t4_busy", 64'(bus.o_busy), 64'(0));
        check_outs("t4");

        // Inter-byte timeout aborts a partial frequency write
        send(8'h02);
        send(8'hFF);
        push('0, 1'b1);
        lat = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.i_rx_byte  = 8'h00;
                bus.i_rx_valid = 1'b0;
            end
            if (bus.o_err) begin
                lat = k;
                break;
            end
        end
        check("t5_timeout_lat", 64'(lat), 64'(TMO + 1));
        check("t5_busy", 64'(bus.o_busy), 64'(0));
        send(8'h01);
        send(8'h03);
        commit(0, 1, 32'h3);
        idle(3);
        check("t5_wave0", 64'(bus.o_wave[WAVE_W-1:0]), 64'h3);

        // Random valid frames with short gaps
        for (int i = 0; i < 24; i++) begin
            ch   = int'($urandom_range(0, N_OSC - 1));
            code = int'($urandom_range(1, 4));
            val  = $urandom;
            case (code)
                1: nb = (WAVE_W + 7) / 8;
                2: nb = (FREQ_W + 7) / 8;
                3: nb = (PHASE_W + 7) / 8;
                default: nb = (AMP_W + 7) / 8;
            endcase
            send({ch[3:0], code[3:0]});
            for (int b = 0; b < nb; b++) begin
                send(val[b*8 +: 8]);
            end
            commit(ch, code, val);
            idle(int'($urandom_range(1, 4)));
        end
        idle(2);
        check_outs("rand");

        // Reset in the middle of an amplitude frame
        send(8'h14);
        send(8'hFF);
        @(negedge clk);
        bus.i_rx_byte  = 8'h00;
        bus.i_rx_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_wave  = '0;
        m_freq  = '0;
        m_phase = '0;
        m_amp   = '0;
        check_outs("t6");
        check("t6_busy",   64'(bus.o_busy),   64'(0));
        check("t6_update", 64'(bus.o_update), 64'(0));
        send(8'hFF);
        push('0, 1'b1);
        idle(3);
        check("t6_busy_end", 64'(bus.o_busy), 64'(0));
        check_outs("t6_end");

        idle(3);
        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/synth_cmd_decoder.md
Name: synth_cmd_decoder

Overview:
- Parametrised SPI command decoder and register file for N_OSC oscillator channels.
- Generalises the fixed two-oscillator command set: OSCn_WAVE, OSCn_FREQ, OSCn_PHASE and OSCn_AMP.
- Sits between the SPI slave byte receiver and the oscillator bank.
- Assembles multi-byte payloads into shadow registers and commits each register atomically.
- Adds a per-channel update strobe, error reporting and an inter-byte timeout that the previous hard-wired decoder lacked.

Parameters:
- N_OSC, 2, number of oscillator channels (1..16).
- WAVE_W, 3, waveform select width.
- FREQ_W, 24, phase-increment width.
- PHASE_W, 16, phase offset width.
- AMP_W, 16, amplitude width.
- TIMEOUT_CYCLES, 2500000, max clocks between payload bytes before the frame is aborted (50 ms at 50 MHz).

Ports:
- i_clk50mhz  in  1  system clock.
- i_rst  in  1  synchronous reset, active-high.
- i_rx_byte  in  8  received SPI byte.
- i_rx_valid  in  1  one-cycle strobe; i_rx_byte is valid when this is high.
- o_wave  out  N_OSC*WAVE_W  per-channel waveform; channel c occupies bits [c*WAVE_W +: WAVE_W].
- o_freq  out  N_OSC*FREQ_W  per-channel frequency word; same packing.
- o_phase  out  N_OSC*PHASE_W  per-channel phase offset; same packing.
- o_amp  out  N_OSC*AMP_W  per-channel amplitude; same packing.
- o_update  out  N_OSC  one-cycle pulse on the channel whose register just committed.
- o_err  out  1  one-cycle pulse on an invalid command or a timeout.
- o_busy  out  1  high while a payload is being collected.

Behaviour:
- Command byte format: [7:4] = channel index, [3:0] = register code.
  - 1 = WAVE, 2 = FREQ, 3 = PHASE, 4 = AMP.
  - Payload length per register = ceil(width/8) bytes. Defaults: WAVE 1, FREQ 3, PHASE 2, AMP 2.
- Payload is little-endian: the first byte is the LSB. Bits above the register width are discarded.
- FSM states: IDLE, PAYLOAD.
- IDLE:
  - Byte 0x00 is ignored (null/kick byte).
  - Valid command: latch channel, register code and byte count; clear the assembly shift register; go to PAYLOAD.
  - Invalid command (register code not 1..4, or channel >= N_OSC): pulse o_err in the next cycle; stay in IDLE.
- PAYLOAD:
  - Each valid byte is shifted into the assembly register and the byte counter decrements.
  - 0x00 is data in this state, not a null byte.
  - On the edge sampling the last byte: write the target register of the latched channel, pulse o_update[ch] in the following cycle, return to IDLE.
  - A byte arriving in the cycle immediately after the commit is decoded as a new command (no dead cycle).
- Outputs change only on commit. Partial payloads are never visible.
- Timeout:
  - In PAYLOAD, a counter clears on every valid byte.
  - When it reaches TIMEOUT_CYCLES-1 with no byte: discard the frame, pulse o_err, go to IDLE.
  - If a byte and the timeout coincide, the byte wins.
- o_busy = (state == PAYLOAD).
- Reset values:
  - All o_wave, o_freq, o_phase and o_amp fields = 0.
  - o_update = 0, o_err = 0, o_busy = 0, state = IDLE.
- Reset mid-frame discards the partial payload. Committed registers also return to 0.
- Consecutive i_rx_valid on back-to-back cycles must be accepted with no loss.

Test Plan:
- Stream 00, 01, 05, 00 -> o_wave ch0 = 5; o_update = 2'b01 for one cycle; no o_err; the leading and trailing 00 bytes are ignored.
- Stream 12, FF, FF, 07 -> o_freq ch1 = 24'h07FFFF; o_freq stays at its old value until the third payload byte; o_busy is high from the command cycle to the commit.
- Stream 04, FF, 7F followed immediately (next cycle) by 03, FF, 03 -> ch0 amp = 16'h7FFF, then ch0 phase = 16'h03FF; two o_update[0] pulses; no byte lost.
- Stream 25 (channel 2, N_OSC=2) then 07 (code 7) -> two o_err pulses; all outputs unchanged; FSM stays in IDLE.
- Stream 02, FF then silence for TIMEOUT_CYCLES (bench sets it to 100) -> o_err pulses; ch0 freq unchanged; a subsequent 01, 03 sets o_wave ch0 = 3.
- Send 14, FF then assert i_rst for 1 cycle, then FF -> no commit; all outputs 0; o_busy = 0; the trailing FF is decoded as an invalid command and pulses o_err.
